// File: rtl/snes_pad_responder.sv
// SNES pad responder: plays the controller side of the serial pad protocol.
// The console's raw latch and clock inputs are synchronised and glitch
// filtered. A small FSM then shifts the active-low button word onto the data
// line, LSB (B) first.
module snes_pad_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter int   WORD_BITS   = 16,
    parameter logic POST_FILL   = 1'b0
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    input  logic                 ENABLE_i,
    input  logic [WORD_BITS-1:0] BUTTONS_i,
    input  logic                 CTRL_LATCH_i,
    input  logic                 CTRL_CLK_i,
    output logic                 CTRL_SDATA_o,
    output logic                 POLL_DONE_o,
    output logic [7:0]           POLL_CNT_o,
    output logic                 EXTRA_CLK_o
);

    localparam int IDX_W = $clog2(WORD_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(WORD_BITS);

    // Input 0 is the latch (idles low), input 1 is the console clock (idles
    // high). The chains are preset to the idle levels so that releasing reset
    // never looks like an edge.
    localparam logic [1:0] PRESET = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCHED,
        ST_SHIFTING,
        ST_DONE
    } state_t;

    logic [1:0] raw_in;
    logic [1:0] hi_all;
    logic [1:0] lo_all;
    logic [1:0] filt;

    assign raw_in = {CTRL_CLK_i, CTRL_LATCH_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FILTER_LEN-1:0]  hist_reg;
            logic                   filt_reg;

            assign hi_all[gi] = &hist_reg;
            assign lo_all[gi] = ~|hist_reg;
            assign filt[gi]   = filt_reg;

            // Synchroniser, sample history and filtered level. The filtered
            // level only moves once the whole history agrees on the new value.
            always_ff @(posedge CLK_i) begin
                if (RST_i) begin
                    sync_reg <= {SYNC_STAGES{PRESET[gi]}};
                    hist_reg <= {FILTER_LEN{PRESET[gi]}};
                    filt_reg <= PRESET[gi];
                end else begin
                    sync_reg <= (sync_reg << 1) | SYNC_STAGES'(raw_in[gi]);
                    hist_reg <= (hist_reg << 1) | FILTER_LEN'(sync_reg[SYNC_STAGES-1]);
                    if (hi_all[gi]) begin
                        filt_reg <= 1'b1;
                    end else if (lo_all[gi]) begin
                        filt_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Edge pulses last exactly one cycle: the filtered register catches up on
    // the following clock edge.
    logic latch_rise;
    logic latch_fall;
    logic clk_rise;

    assign latch_rise = hi_all[0] & ~filt[0];
    assign latch_fall = lo_all[0] &  filt[0];
    assign clk_rise   = hi_all[1] & ~filt[1];

    state_t               state_reg, state_next;
    logic [WORD_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic                 extra_reg, extra_next;
    logic                 done_reg, done_next;
    logic                 sdata_reg, sdata_next;

    // Protocol FSM: next state, shift register, counters and next line level.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        extra_next = extra_reg;
        done_next  = 1'b0;
        sdata_next = 1'b1;

        if (!ENABLE_i) begin
            state_next = ST_IDLE;
        end else if (latch_rise) begin
            // A latch rise wins over everything, including a clock edge in the
            // same cycle. It also abandons a poll in progress.
            state_next = ST_LATCHED;
            extra_next = 1'b0;
        end else begin
            case (state_reg)
                ST_LATCHED: begin
                    // A clock rise in the same cycle as the fall is not counted.
                    if (latch_fall) begin
                        state_next = ST_SHIFTING;
                        idx_next   = '0;
                    end
                end
                ST_SHIFTING: begin
                    if (clk_rise) begin
                        shift_next = {POST_FILL, shift_reg[WORD_BITS-1:1]};
                        if (idx_reg == LAST_IDX) begin
                            state_next = ST_DONE;
                            idx_next   = END_IDX;
                            done_next  = 1'b1;
                            cnt_next   = cnt_reg + 8'd1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        extra_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Transparent parallel load while latched. Entering SHIFTING keeps the
        // word loaded on the last latched cycle.
        if (state_next == ST_LATCHED) begin
            shift_next = ~BUTTONS_i;
        end

        case (state_next)
            ST_IDLE:  sdata_next = 1'b1;
            ST_DONE:  sdata_next = POST_FILL;
            default:  sdata_next = shift_next[0];
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_reg <= ST_IDLE;
            shift_reg <= '1;
            idx_reg   <= '0;
            cnt_reg   <= 8'd0;
            extra_reg <= 1'b0;
            done_reg  <= 1'b0;
            sdata_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            extra_reg <= extra_next;
            done_reg  <= done_next;
            sdata_reg <= sdata_next;
        end
    end

    assign CTRL_SDATA_o = sdata_reg;
    assign POLL_DONE_o  = done_reg;
    assign POLL_CNT_o   = cnt_reg;
    assign EXTRA_CLK_o  = extra_reg;

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Controller-side responder for the SNES serial pad protocol; it drives the data line from the controller to the console.
- The console drives CTRL_LATCH and CTRL_CLK. The block shifts out a 16-bit button word on CTRL_SDATA_o in the 4021-style order: bit0 = B first, bit15 last.
- It runs in the MCLKO domain (~21.477 MHz) beside the controller-sniffing IGR logic. It lets the test board inject pad states from the soft CPU config output.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each console input.
- FILTER_LEN, 3, consecutive equal synchronized samples required to change a filtered input.
- WORD_BITS, 16, bits shifted per poll.
- POST_FILL, 1'b0, line level driven once WORD_BITS bits are exhausted.

Ports:
- CLK_i  in  1  system clock (MCLKO).
- RST_i  in  1  synchronous, active-high reset.
- ENABLE_i  in  1  0 = responder disabled.
- BUTTONS_i  in  WORD_BITS  button word, 1 = pressed; bit0 = B.
- CTRL_LATCH_i  in  1  console latch, raw, asynchronous.
- CTRL_CLK_i  in  1  console clock, raw, asynchronous, idle high.
- CTRL_SDATA_o  out  1  serial data line, active-low (pressed = 0).
- POLL_DONE_o  out  1  one-cycle pulse when the last bit has been shifted.
- POLL_CNT_o  out  8  completed polls, wraps 255 -> 0.
- EXTRA_CLK_o  out  1  sticky flag: CTRL_CLK edge seen after the word was exhausted; cleared by the next latch rise.

Behaviour:
- Reset (RST_i high at a CLK_i edge) forces the following, regardless of other inputs:
  - State = IDLE; CTRL_SDATA_o = 1; POLL_DONE_o = 0; POLL_CNT_o = 0; EXTRA_CLK_o = 0; bit index = 0.
  - Latch sync/filter chain preset to 0; clock sync/filter chain preset to 1, so no edge is produced on reset release.
- Input path, per input:
  - SYNC_STAGES flops, then the filter.
  - The filtered value changes only when the last FILTER_LEN synchronized samples all equal the new value.
  - Edges are detected on the filtered value.
  - Latency from the first CLK_i edge sampling a new raw level to the edge pulse: SYNC_STAGES+FILTER_LEN cycles. CTRL_SDATA_o (registered) updates one cycle later, i.e. 6 cycles total with the defaults.
  - Glitches shorter than FILTER_LEN cycles after sync produce no edge.
- Shift register: WORD_BITS wide and holds the active-low line values, i.e. ~BUTTONS_i. CTRL_SDATA_o = shift[0] in LATCHED and SHIFTING.
- IDLE:
  - Output 1. Clock edges ignored.
  - Latch rise -> LATCHED.
- LATCHED (filtered latch = 1):
  - Shift register reloaded from ~BUTTONS_i every cycle (transparent parallel load).
  - Clock edges ignored.
  - Latch fall -> SHIFTING, index 0, load frozen at the value of the last LATCHED cycle.
- SHIFTING:
  - On each filtered clock rising edge: shift right, index+1.
  - When index reaches WORD_BITS-1 and another rising edge occurs: index = WORD_BITS -> DONE. POLL_DONE_o pulses in that cycle and POLL_CNT_o increments.
- DONE:
  - Output POST_FILL.
  - Further rising edges set EXTRA_CLK_o.
  - Latch rise -> LATCHED and clears EXTRA_CLK_o.
- Latch rise in any enabled state -> LATCHED. A latch rise in SHIFTING aborts the poll with no POLL_DONE_o and no count.
- Simultaneous events:
  - Latch rise + clock rise in the same cycle: latch wins, clock ignored.
  - Latch fall + clock rise in the same cycle: enter SHIFTING at index 0, clock not counted.
- ENABLE_i = 0:
  - Forces IDLE, output 1; counters and EXTRA_CLK_o hold.
  - Re-enabling mid-latch-high does not enter LATCHED until the next filtered latch rise.
- BUTTONS_i changes during SHIFTING do not affect the word in flight.

Test Plan:
1. Reset release with CTRL_CLK_i = 1, CTRL_LATCH_i = 0 -> CTRL_SDATA_o = 1; no POLL_DONE_o for 100 cycles.
2. BUTTONS_i = 16'h8001; latch high 256 cycles, low; then 16 clock low/high pulses of 128/128 cycles -> sequence:
   - line 0 during latch;
   - after clock rises 1–14: line 1;
   - after clock rise 15: line 0;
   - on clock rise 16: POLL_DONE_o pulses, POLL_CNT_o = 1, line = POST_FILL (0).
3. BUTTONS_i changed from 16'h0000 to 16'hFFFF during the latch high, then to 16'h0000 after latch fall -> all 16 bits read 0 (pressed). The word is frozen at latch fall.
4. A 2-cycle clock low glitch during SHIFTING plus a 17th clock pulse in DONE -> glitch ignored (bit order intact); EXTRA_CLK_o = 1; next latch rise clears it.
5. Latch rise after 5 clock pulses -> return to LATCHED, POLL_CNT_o unchanged. Run 256 complete polls -> POLL_CNT_o wraps to 0.
6. RST_i asserted at clock pulse 8 -> next cycle: IDLE, line 1, counters 0. ENABLE_i = 0 during a poll -> line 1 and the poll is discarded.
